// File: rtl/code_counter.sv
// Up/down counter with load, wrap/saturate ends and a registered output code
// (one-hot-step, reflected Gray or binary) that tracks count with no skew.
module code_counter #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned MODE  = 0,
    parameter bit          WRAP  = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      up,
    input  logic                      load,
    input  logic [WIDTH-1:0]          load_val,
    output logic [WIDTH-1:0]          count,
    output logic [(2**WIDTH)-2:0]     code_out,
    output logic                      tc,
    output logic                      sat
);

    localparam int unsigned OUT_W = (2 ** WIDTH) - 1;
    localparam logic [WIDTH-1:0] MAX = '1;

    typedef enum logic [1:0] {
        CODE_ONEHOT = 2'd0,
        CODE_GRAY   = 2'd1,
        CODE_BIN    = 2'd2
    } code_e;

    localparam code_e CODE = (MODE == 0) ? CODE_ONEHOT :
                             (MODE == 1) ? CODE_GRAY   : CODE_BIN;

    function automatic logic [OUT_W-1:0] encode(input logic [WIDTH-1:0] n);
        logic [OUT_W-1:0] res;
        res = '0;
        case (CODE)
            CODE_ONEHOT: if (n != '0) res = OUT_W'(1) << (n - 1'b1);
            CODE_GRAY:   res = OUT_W'(n ^ (n >> 1));
            default:     res = OUT_W'(n);
        endcase
        return res;
    endfunction

    logic [WIDTH-1:0] count_q, count_d;
    logic [OUT_W-1:0] code_q, code_d;
    logic             sat_q, sat_d;
    logic             at_max, at_zero;

    assign at_max  = (count_q == MAX);
    assign at_zero = (count_q == '0);

    always_comb begin
        count_d = count_q;
        sat_d   = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            if (up) begin
                if (!at_max)   count_d = count_q + 1'b1;
                else if (WRAP) count_d = '0;
                else           sat_d   = 1'b1;
            end else begin
                if (!at_zero)  count_d = count_q - 1'b1;
                else if (WRAP) count_d = MAX;
                else           sat_d   = 1'b1;
            end
        end
        // Encode the next count so the code register lands together with count.
        code_d = encode(count_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            code_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            code_q  <= code_d;
            sat_q   <= sat_d;
        end
    end

    assign count    = count_q;
    assign code_out = code_q;
    assign sat      = sat_q;
    assign tc       = en & ~load & ((up & at_max) | (~up & at_zero));

endmodule

// File: doc/code_counter.md
# code_counter

Parametrised up/down counter whose state is presented, registered, in a selectable output code: one-hot-step (0 → all-zero, k → bit k-1 set), reflected Gray, or plain binary. It generalises the team's combinational 3-bit code encoders into a clocked, loadable sequence source. Typical uses are driving LED bars, position strobes, and Gray-coded pointers for clock-domain-crossing experiments in the lab designs.

## Interface
- WIDTH, 3, counter width in bits (2..6).
- MODE, 0, output code: 0 = one-hot-step, 1 = Gray, 2 = binary. Any other value behaves as 2.
- WRAP, 1, 1 = wrap around at the ends; 0 = saturate at the ends.
- OUT_W, 2**WIDTH-1, derived localparam giving the width of code_out (fixed for all modes).

- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- en, in, 1, count enable.
- up, in, 1, direction: 1 = increment, 0 = decrement.
- load, in, 1, synchronous load strobe.
- load_val, in, WIDTH, value to load.
- count, out, WIDTH, registered binary count.
- code_out, out, OUT_W, registered encoding of count.
- tc, out, 1, terminal count (combinational).
- sat, out, 1, registered flag: the last enabled step was blocked by saturation.

## Operation
- Next-count priority:
  - load = 1: count ← load_val. Direction and enable are ignored.
  - else en = 1, up = 1: count ← count+1.
  - else en = 1, up = 0: count ← count−1.
  - else: count holds.
- Ends of range, WIDTH-bit arithmetic:
  - WRAP = 1: MAX+1 → 0 and 0−1 → MAX, where MAX = 2**WIDTH−1.
  - WRAP = 0: the count holds at MAX when stepping up and at 0 when stepping down.
- sat is registered and set to 1 exactly when WRAP = 0, en = 1, load = 0, and the step was blocked at an end. Any other clock edge clears it to 0. sat is always 0 when WRAP = 1.
- code_out is registered from the next count, so in every cycle code_out equals encode(count). There is no skew between count and code_out.
- Encodings, for count = n:
  - MODE 0: n = 0 gives all zeros; otherwise only bit n−1 is set.
  - MODE 1: n ^ (n>>1), zero-extended to OUT_W.
  - MODE 2: n, zero-extended to OUT_W.
- tc = en & ~load & ((up & count==MAX) | (~up & count==0)).
- Simultaneous load and en: load wins, and sat is cleared.

## Timing
- Reset (rst_n low, at any time including mid-count) immediately forces count = 0, code_out = 0, and sat = 0. tc then follows its equation, so it equals en & ~load & ~up.
- Reset release: the first edge after rst_n goes high acts normally. There is no dead cycle.
- Latency is 1 clock from en/load to count and code_out. tc is combinational and therefore has zero latency. sat has 1 clock of latency.
- Changing direction takes effect on the next enabled edge. There is no pipeline, so there is no overshoot.
- All outputs are stable between edges. Only tc depends combinationally on the inputs.

## Test plan
- Reset and Gray wrap (WIDTH = 3, MODE = 1): pulse rst_n low mid-count. Then hold en = 1, up = 1 for 9 edges. Required: count = 0 and code_out = 0 during reset; after release, code_out runs 1, 3, 2, 6, 7, 5, 4, 0, 1. tc = 1 only while count = 7. Every step changes exactly one bit.
- One-hot-step down (WIDTH = 3, MODE = 0): load_val = 7 with load = 1, then en = 1, up = 0 for 8 edges. Required: code_out = 64, 32, 16, 8, 4, 2, 1, 0, then 64 after the wrap. tc = 1 while count = 0.
- Saturation (WRAP = 0, WIDTH = 3, MODE = 2): load 6, then step up for 3 edges. Required: count = 7, 7, 7. sat is 0 after the first edge and 1 after the second and third. Then step down once: count = 6, sat = 0.
- Load priority: count = 2, assert load = 1, en = 1, up = 1, load_val = 5 together. Required: count = 5 next cycle (not 3), tc = 0 during the load cycle, sat = 0.
- Hold and direction change (WIDTH = 4, MODE = 1): count = 9, set en = 0 for 3 edges, then en = 1 with up toggling each edge. Required: count holds at 9, then alternates 10, 9, 10. code_out alternates 15, 13, 15 (Gray of 10, 9, 10).
- Width sweep: run WIDTH = 2 and WIDTH = 6 in all three MODEs for a full up cycle. Required: code_out equals a reference encode(count) every cycle, OUT_W = 3 and 63 respectively, and tc asserts once per cycle, at MAX.
